// File: rtl/trace_pkg.sv
// Shared definitions for the trace pair sequencer: record width, record field offsets, FSM states.
// TRACE_STOP_ON_FAIL_EN adds the HALT state used when streaming stops at the first failure.
package trace_pkg;

  localparam int STATE_W  = 1455;

  // Field offsets inside one state record
  localparam int ERR_BIT  = 73;
  localparam int INSN_LSB = 74;
  localparam int INSN_MSB = 193;
  localparam int TS_LSB   = 832;
  localparam int TS_MSB   = 895;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_PRIMED = 2'd1,
    ST_DONE   = 2'd2
`ifdef TRACE_STOP_ON_FAIL_EN
    ,
    ST_HALT   = 2'd3
`endif
  } trace_state_e;

endpackage

// File: rtl/trace_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones once reached.
module trace_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/trace_pair_sequencer.sv
// Feeds consecutive (current, next) record pairs to the transition checker and accumulates verdicts.
// TRACE_STOP_ON_FAIL_EN: first failing pair halts the trace (HALT state, done=1, pass=0).
module trace_pair_sequencer #(
  parameter int STATE_W = trace_pkg::STATE_W,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [STATE_W-1:0] s_state,
  input  logic               s_last,
  output logic [STATE_W-1:0] pair_current,
  output logic [STATE_W-1:0] pair_next,
  output logic               pair_valid,
  input  logic               chk_result,
  output logic [CNT_W-1:0]   steps,
  output logic [CNT_W-1:0]   fails,
  output logic               fail_valid,
  output logic [CNT_W-1:0]   fail_index,
  output logic               done,
  output logic               pass,
  output logic [1:0]         dbg_state
);

  import trace_pkg::*;

  // Handshake: a record transfers on any rising edge where s_valid && s_ready; s_ready
  // depends only on FSM state, never on s_valid, and s_valid/s_state/s_last must stay stable until taken.

  trace_state_e           state, state_nxt;
  logic [STATE_W-1:0]     prev;
  logic                   last_pending;
  logic                   soft_rst;
  logic                   accept;
  logic                   load_pair;
  logic                   eval_fail;
  logic                   halt_now;

  assign soft_rst  = !rst_n || clear;
  assign accept    = s_valid && s_ready;
  assign eval_fail = pair_valid && !chk_result;

`ifdef TRACE_STOP_ON_FAIL_EN
  assign halt_now  = eval_fail;
  assign done      = (state == ST_DONE) || (state == ST_HALT);
`else
  assign halt_now  = 1'b0;
  assign done      = (state == ST_DONE);
`endif

  // Records arriving after s_last but before done are not part of the trace and are dropped.
  assign load_pair = accept && (state == ST_PRIMED) && !last_pending && !halt_now;
  assign pass      = (state == ST_DONE) && (fails == '0);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (soft_rst) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    case (state)
      ST_EMPTY: begin
        s_ready = 1'b1;
        if (s_valid) begin
          state_nxt = s_last ? ST_DONE : ST_PRIMED;
        end
      end
      ST_PRIMED: begin
        s_ready = 1'b1;
`ifdef TRACE_STOP_ON_FAIL_EN
        if (halt_now) begin
          state_nxt = ST_HALT;
        end else
`endif
        if (pair_valid && last_pending) begin
          state_nxt = ST_DONE;
        end
      end
      default: begin
        state_nxt = state;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (soft_rst) begin
      prev         <= '0;
      pair_current <= '0;
      pair_next    <= '0;
      pair_valid   <= 1'b0;
      last_pending <= 1'b0;
      fail_valid   <= 1'b0;
      fail_index   <= '0;
    end else begin
      pair_valid <= load_pair;
      if (load_pair) begin
        pair_current <= prev;
        pair_next    <= s_state;
      end
      if ((accept && (state == ST_EMPTY)) || load_pair) begin
        prev <= s_state;
      end
      if (pair_valid && last_pending) begin
        last_pending <= 1'b0;
      end
      if (load_pair && s_last) begin
        last_pending <= 1'b1;
      end
      // Old steps value is the 0-based index of the pair being judged now.
      if (eval_fail && !fail_valid) begin
        fail_valid <= 1'b1;
        fail_index <= steps;
      end
    end
  end

  trace_sat_counter #(.CNT_W(CNT_W)) u_steps (
    .clk   (clk),
    .clr   (soft_rst),
    .inc   (pair_valid),
    .count (steps)
  );

  trace_sat_counter #(.CNT_W(CNT_W)) u_fails (
    .clk   (clk),
    .clr   (soft_rst),
    .inc   (eval_fail),
    .count (fails)
  );

endmodule

// File: tb/tb_trace_pair_sequencer.sv
// Randomized bench for trace_pair_sequencer: a 32-bit and a 3-bit-counter instance share stimulus;
// a checker stub fails any pair whose next record carries the error flag.
module tb_trace_pair_sequencer;
  import trace_pkg::*;

`ifdef TRACE_STOP_ON_FAIL_EN
  localparam bit STOP_EN = 1'b1;
`else
  localparam bit STOP_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n, clear, s_valid, s_last;
  logic [STATE_W-1:0] s_state;

  logic               s_ready_a, pair_valid_a, fail_valid_a, done_a, pass_a, chk_result_a;
  logic [STATE_W-1:0] pair_current_a, pair_next_a;
  logic [31:0]        steps_a, fails_a, fail_index_a;
  logic [1:0]         dbg_state_a;

  logic               s_ready_b, pair_valid_b, fail_valid_b, done_b, pass_b, chk_result_b;
  logic [STATE_W-1:0] pair_current_b, pair_next_b;
  logic [2:0]         steps_b, fails_b, fail_index_b;
  logic [1:0]         dbg_state_b;

  int total = 0;
  int bad   = 0;

  logic [STATE_W-1:0] recs[$];
  logic [63:0]        exp_q[$];

  assign chk_result_a = !pair_next_a[ERR_BIT];
  assign chk_result_b = !pair_next_b[ERR_BIT];

  trace_pair_sequencer #(.STATE_W(STATE_W), .CNT_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .s_valid(s_valid), .s_ready(s_ready_a),
    .s_state(s_state), .s_last(s_last), .pair_current(pair_current_a), .pair_next(pair_next_a),
    .pair_valid(pair_valid_a), .chk_result(chk_result_a), .steps(steps_a), .fails(fails_a),
    .fail_valid(fail_valid_a), .fail_index(fail_index_a), .done(done_a), .pass(pass_a),
    .dbg_state(dbg_state_a)
  );

  trace_pair_sequencer #(.STATE_W(STATE_W), .CNT_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .s_valid(s_valid), .s_ready(s_ready_b),
    .s_state(s_state), .s_last(s_last), .pair_current(pair_current_b), .pair_next(pair_next_b),
    .pair_valid(pair_valid_b), .chk_result(chk_result_b), .steps(steps_b), .fails(fails_b),
    .fail_valid(fail_valid_b), .fail_index(fail_index_b), .done(done_b), .pass(pass_b),
    .dbg_state(dbg_state_b)
  );

  // Clock
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] fold(input logic [STATE_W-1:0] r);
    logic [63:0] f = '0;
    for (int i = 0; i < STATE_W; i++) f[i % 64] ^= r[i];
    return f;
  endfunction

  function automatic logic [STATE_W-1:0] rand_rec(input bit err);
    logic [STATE_W-1:0] r;
    for (int i = 0; i < STATE_W; i++) r[i] = 1'($urandom_range(1, 0));
    r[ERR_BIT] = err;
    return r;
  endfunction

  function automatic int sat7(input int x);
    return (x > 7) ? 7 : x;
  endfunction

  // Scoreboard: every presented pair must match the next expected (current, next) record pair.
  always @(negedge clk) begin
    if (pair_valid_a) begin
      if (exp_q.size() < 2) begin
        check("pair_extra", 64'(exp_q.size()), 64'd2);
      end else begin
        check("pair_cur", fold(pair_current_a), exp_q.pop_front());
        check("pair_nxt", fold(pair_next_a), exp_q.pop_front());
      end
    end
  end

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); @(negedge clk);
    clear = 1'b0;
    check("clr_steps", 64'(steps_a), 64'd0);
    check("clr_state", 64'(dbg_state_a), 64'd0);
  endtask

  task automatic run_trace(input int n, input logic [31:0] err_mask, input int gap_pct);
    int p, ff, eval_cnt, fcnt, idx, budget;
    bit early_halt, halted, rdy;
    recs.delete();
    exp_q.delete();
    for (int i = 0; i < n; i++) recs.push_back(rand_rec(err_mask[i]));
    p  = n - 1;
    ff = -1;
    for (int i = 0; i < p; i++) if (recs[i+1][ERR_BIT] && ff < 0) ff = i;
    eval_cnt = (STOP_EN && ff >= 0) ? ff + 1 : p;
    fcnt = 0;
    for (int i = 0; i < eval_cnt; i++) if (recs[i+1][ERR_BIT]) fcnt++;
    halted     = STOP_EN && ff >= 0;
    early_halt = halted && ff < p - 1;
    for (int i = 0; i < eval_cnt; i++) begin
      exp_q.push_back(fold(recs[i]));
      exp_q.push_back(fold(recs[i+1]));
    end

    idx = 0;
    budget = 400;
    while (idx < n && budget > 0) begin
      budget--;
      if ($urandom_range(99, 0) < gap_pct) begin
        s_valid = 1'b0; s_last = 1'b0;
        @(posedge clk); @(negedge clk);
      end else begin
        s_valid = 1'b1; s_state = recs[idx]; s_last = (idx == n - 1);
        rdy = s_ready_a;
        @(posedge clk); @(negedge clk);
        if (rdy) idx++;
        else if (done_a) break;
      end
    end
    s_valid = 1'b0; s_last = 1'b0;
    if (idx < n && !done_a) check("drive_timeout", 64'(idx), 64'(n));

    if (idx == n && !early_halt) begin
      if (n == 1) begin
        check("done_lat1", 64'(done_a), 64'd1);
        check("pass_lat1", 64'(pass_a), 64'd1);
      end else begin
        check("done_early", 64'(done_a), 64'd0);
        check("rdy_hold", 64'(s_ready_a), 64'd1);
        @(negedge clk);
        check("done_lat2", 64'(done_a), 64'd1);
        check("rdy_drop", 64'(s_ready_a), 64'd0);
      end
    end
    budget = 10;
    while (!done_a && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    repeat (2) @(negedge clk);
    check("done", 64'(done_a), 64'd1);
    check("steps", 64'(steps_a), 64'(eval_cnt));
    check("fails", 64'(fails_a), 64'(fcnt));
    check("fail_valid", 64'(fail_valid_a), 64'(ff >= 0));
    check("fail_index", 64'(fail_index_a), (ff >= 0) ? 64'(ff) : 64'd0);
    check("pass", 64'(pass_a), 64'(fcnt == 0 && !halted));
    check("s_ready_done", 64'(s_ready_a), 64'd0);
    check("state", 64'(dbg_state_a), halted ? 64'd3 : 64'd2);
    check("pairs_left", 64'(exp_q.size()), 64'd0);
    check("sat_steps", 64'(steps_b), 64'(sat7(eval_cnt)));
    check("sat_fails", 64'(fails_b), 64'(sat7(fcnt)));
    check("sat_index", 64'(fail_index_b), (ff >= 0) ? 64'(sat7(ff)) : 64'd0);
    check("sat_pass", 64'(pass_b), 64'(fcnt == 0 && !halted));
  endtask

  initial begin
    logic [31:0] mask;
    rst_n = 1'b0; clear = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_state = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_steps", 64'(steps_a), 64'd0);
    check("rst_fails", 64'(fails_a), 64'd0);
    check("rst_done", 64'(done_a), 64'd0);
    check("rst_pass", 64'(pass_a), 64'd0);
    check("rst_pv", 64'(pair_valid_a), 64'd0);
    check("rst_ready", 64'(s_ready_a), 64'd1);
    check("rst_state", 64'(dbg_state_a), 64'd0);

    run_trace(5, 32'h0, 0);
    do_clear();
    run_trace(5, 32'b10100, 0);
    do_clear();
    run_trace(1, 32'h0, 0);
    do_clear();
    run_trace(10, 32'h0, 40);
    do_clear();

    // Reset while a pair is in flight: the pair is discarded and everything returns to zero.
    recs.delete(); exp_q.delete();
    for (int i = 0; i < 3; i++) recs.push_back(rand_rec(1'b0));
    exp_q.push_back(fold(recs[0]));
    exp_q.push_back(fold(recs[1]));
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1; s_state = recs[i]; s_last = 1'b0;
      @(posedge clk); @(negedge clk);
    end
    check("mid_pv", 64'(pair_valid_a), 64'd1);
    rst_n = 1'b0; s_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    check("mid_steps", 64'(steps_a), 64'd0);
    check("mid_fails", 64'(fails_a), 64'd0);
    check("mid_fvalid", 64'(fail_valid_a), 64'd0);
    check("mid_findex", 64'(fail_index_a), 64'd0);
    check("mid_done", 64'(done_a), 64'd0);
    check("mid_pass", 64'(pass_a), 64'd0);
    check("mid_pv_clr", 64'(pair_valid_a), 64'd0);
    check("mid_cur", fold(pair_current_a), 64'd0);
    check("mid_state", 64'(dbg_state_a), 64'd0);
    check("mid_ready", 64'(s_ready_a), 64'd1);
    check("mid_steps_b", 64'(steps_b), 64'd0);

    run_trace(12, 32'h0, 0);

    for (int t = 0; t < 6; t++) begin
      do_clear();
      mask = '0;
      for (int i = 0; i < 12; i++) mask[i] = ($urandom_range(3, 0) == 0);
      run_trace(int'($urandom_range(12, 1)), mask, int'($urandom_range(50, 0)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
